// File: rtl/risci_pkg.sv
// Shared types and sizing for the issue stage.
// Register indices, buffered entries and the per-register hazard test.
package risci_pkg;

  localparam int XWDT  = 6;
  localparam int XN    = 64;
  localparam int DEPTH = 4;
  localparam int PWDT  = 32;
  localparam int PTRW  = $clog2(DEPTH);
  localparam int CWDT  = $clog2(DEPTH + 1);

  typedef logic [XWDT-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rs1;
    reg_idx_t        rs2;
    reg_idx_t        rd;
    logic [PWDT-1:0] payload;
  } issue_entry_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 never blocks; last_rd covers the scoreboard's one-cycle set lag
  function automatic logic reg_hz(
    input reg_idx_t        r,
    input logic [XN-1:0]   locks,
    input reg_idx_t        last
  );
    return (r != REG_ZERO) && (locks[r] || (r == last));
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// In-order ring buffer of decoded instructions.
// Pointers wrap naturally because DEPTH is a power of two.
module issue_fifo
  import risci_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  issue_entry_t wdata_i,
  output issue_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  issue_entry_t    mem_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [CWDT-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PTRW'(1);
    if (pop_i)  head_d = head_q + PTRW'(1);
    count_d = count_q + CWDT'(push_i) - CWDT'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  assign head_o  = mem_q[head_q];
  assign full_o  = (count_q == CWDT'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/issue_gate.sv
// Issue stage: buffers decoded instructions and releases the head
// only when none of its registers is locked by the scoreboard.
module issue_gate
  import risci_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_idx_t        in_rs1,
  input  reg_idx_t        in_rs2,
  input  reg_idx_t        in_rd,
  input  logic [PWDT-1:0] in_payload,
  input  logic [XN-1:0]   rlocks,
  output logic            out_valid,
  input  logic            out_ready,
  output reg_idx_t        out_rs1,
  output reg_idx_t        out_rs2,
  output reg_idx_t        out_rd,
  output logic [PWDT-1:0] out_payload,
  output reg_idx_t        rset,
  output logic [31:0]     stall_cycles
);

  issue_entry_t wdata;
  issue_entry_t head;
  logic         full, empty;
  logic         push, pop;
  logic         hazard;

  reg_idx_t     last_rd_q, last_rd_d;
  logic [31:0]  stall_q, stall_d;

  assign wdata = '{rs1: in_rs1, rs2: in_rs2,
                   rd: in_rd, payload: in_payload};

  issue_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign hazard = reg_hz(head.rs1, rlocks, last_rd_q)
                | reg_hz(head.rs2, rlocks, last_rd_q)
                | reg_hz(head.rd,  rlocks, last_rd_q);

  assign in_ready  = !full;
  assign out_valid = !empty && !hazard;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_rs1     = REG_ZERO;
    out_rs2     = REG_ZERO;
    out_rd      = REG_ZERO;
    out_payload = '0;
    if (!empty) begin
      out_rs1     = head.rs1;
      out_rs2     = head.rs2;
      out_rd      = head.rd;
      out_payload = head.payload;
    end
  end

  assign rset = pop ? head.rd : REG_ZERO;

  always_comb begin
    last_rd_d = rset;
    stall_d   = stall_q;
    if (!empty && hazard && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd_q <= REG_ZERO;
      stall_q   <= '0;
    end else begin
      last_rd_q <= last_rd_d;
      stall_q   <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_gate.sv
// Bench for issue_gate: queue-based reference model plus directed scenarios.
// A small scoreboard model closes the rset -> rlocks loop.
module tb_issue_gate;
  import risci_pkg::*;

  logic            clk = 0;
  logic            rst = 1;
  logic            in_valid = 0;
  logic            in_ready;
  logic [5:0]      in_rs1 = 0, in_rs2 = 0, in_rd = 0;
  logic [31:0]     in_payload = 0;
  logic [63:0]     rlocks;
  logic            out_valid;
  logic            out_ready = 0;
  logic [5:0]      out_rs1, out_rs2, out_rd, rset;
  logic [31:0]     out_payload;
  logic [31:0]     stall_cycles;

  logic [63:0]     sb_q;
  logic [63:0]     force_m = 0;
  logic [5:0]      rclear = 0;
  logic [5:0]      rset_s = 0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0]  rs1, rs2, rd;
    logic [31:0] pl;
  } ent_t;

  ent_t        q[$];
  logic [5:0]  m_last = 0;
  logic [31:0] m_stall = 0;

  always #5 clk = ~clk;

  issue_gate dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_payload(in_payload), .rlocks(rlocks),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_payload(out_payload), .rset(rset),
    .stall_cycles(stall_cycles)
  );

  assign rlocks = sb_q | force_m;

  always @(negedge clk) rset_s <= rset;

  always @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else begin
      logic [63:0] n;
      n = sb_q;
      if (rclear != 0) n[rclear] = 1'b0;
      if (rset_s != 0) n[rset_s] = 1'b1;
      sb_q <= n;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit blocked(logic [5:0] r);
    return (r != 0) && (rlocks[r] || r == m_last);
  endfunction

  function automatic bit head_hz();
    if (q.size() == 0) return 0;
    return blocked(q[0].rs1) || blocked(q[0].rs2) || blocked(q[0].rd);
  endfunction

  // reference model: advances on each edge from the rules, not from the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_last = 0;
      m_stall = 0;
    end else begin
      bit hz, fire, pushok;
      ent_t h, e;
      hz = head_hz();
      fire = (q.size() != 0) && !hz && out_ready;
      pushok = in_valid && (q.size() != DEPTH);
      h = (q.size() != 0) ? q[0] : '{0, 0, 0, 0};
      if (q.size() != 0 && hz && m_stall != 32'hffff_ffff) m_stall++;
      m_last = fire ? h.rd : 6'd0;
      if (fire) void'(q.pop_front());
      if (pushok) begin
        e = '{in_rs1, in_rs2, in_rd, in_payload};
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    ent_t h;
    bit v;
    h = (q.size() != 0) ? q[0] : '{0, 0, 0, 0};
    v = (q.size() != 0) && !head_hz();
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("out_valid", out_valid, v);
    chk("out_rs1", out_rs1, h.rs1);
    chk("out_rs2", out_rs2, h.rs2);
    chk("out_rd", out_rd, h.rd);
    chk("out_payload", out_payload, h.pl);
    chk("rset", rset, (v && out_ready) ? h.rd : 6'd0);
    chk("stall", stall_cycles, m_stall);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [5:0] a, logic [5:0] b, logic [5:0] d,
                       logic [31:0] p);
    in_valid = 1;
    in_rs1 = a; in_rs2 = b; in_rd = d; in_payload = p;
  endtask

  task automatic idle();
    in_valid = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_payload = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    out_ready = 0;
    force_m = 0;
    rclear = 0;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    tick();

    // reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(6'(i + 1), 0, 0, 32'h100 + i);
      tick();
    end
    idle();
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_rset", rset, 0);
    chk("rst_stall", stall_cycles, 0);
    tick();
    rst = 0;
    tick();

    // free issue: offered one cycle after acceptance
    out_ready = 1;
    drive(1, 2, 3, 32'hF00D);
    #1;
    chk("nobypass", out_valid, 0);
    tick();
    idle();
    #1;
    chk("free_valid", out_valid, 1);
    chk("free_rset", rset, 3);
    tick();
    chk("free_rset0", rset, 0);

    // RAW through last_rd and the scoreboard
    do_reset();
    out_ready = 1;
    drive(0, 0, 5, 32'h5);
    tick();
    drive(5, 0, 6, 32'h6);
    tick();
    idle();
    #1;
    chk("raw_hold1", out_valid, 0);
    tick();
    tick();
    chk("raw_hold2", out_valid, 0);
    rclear = 5;
    tick();
    rclear = 0;
    #1;
    chk("raw_go", out_valid, 1);
    chk("raw_rset", rset, 6);
    tick();

    // WAW on a locked rd, then x0 ignored
    do_reset();
    force_m[7] = 1;
    drive(0, 0, 7, 32'h7);
    tick();
    idle();
    #1;
    chk("waw_hold", out_valid, 0);
    chk("waw_stall0", stall_cycles, 0);
    tick();
    tick();
    tick();
    chk("waw_stall3", stall_cycles, 3);
    force_m = 0;
    #1;
    chk("waw_free", out_valid, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    force_m[0] = 1;
    drive(0, 9, 0, 32'hA0);
    tick();
    idle();
    #1;
    chk("x0_valid", out_valid, 1);
    out_ready = 1;
    tick();
    force_m = 0;
    out_ready = 0;

    // fill to DEPTH, then stream across pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(6'(8 + i), 6'(16 + i), 0, 32'hA000 + i);
      tick();
      if (i == 3) chk("full_ready", in_ready, 0);
    end
    chk("full_head", out_payload, 32'hA000);
    out_ready = 1;
    for (int i = 5; i < 15; i++) begin
      drive(6'(8 + i), 6'(16 + i), 0, 32'hA000 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) tick();
    chk("drained", out_valid, 0);

    // backpressure on a hazard-free head
    do_reset();
    drive(10, 11, 12, 32'hBEEF);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_rset", rset, 0);
      chk("bp_pl", out_payload, 32'hBEEF);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_fire", rset, 12);
    tick();
    chk("bp_once", rset, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
